// File: rtl/part_mux_scanner.sv
// part_mux_scanner: registered NCH:1 x WIDTH selector with valid/ready handshake and auto-scan sequencer
//   clk, reset_n         clock, async active-low reset
//   in_data              channel k at [k*WIDTH +: WIDTH]
//   sel, en_n, mode      direct select, active-low enable, 00 direct / 01 scan-once / 10 scan-continuous / 11 hold
//   start                one-cycle scan start pulse
//   q, q_n, q_chan       registered sample, its complement, source channel
//   q_valid, q_ready     output handshake (ready used in scan modes only)
//   busy, done           scanning / one-cycle end of scan-once
module part_mux_scanner #(
    parameter int WIDTH = 1,
    parameter int NCH   = 8,
    parameter int SELW  = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]      sel,
    input  logic                 en_n,
    input  logic [1:0]           mode,
    input  logic                 start,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     q_n,
    output logic [SELW-1:0]      q_chan,
    output logic                 q_valid,
    input  logic                 q_ready,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic {IDLE, SCAN} state_t;
    localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);
    state_t          state;
    logic [SELW-1:0] idx;
    logic [SELW-1:0] nxt;
    logic [WIDTH-1:0] ch [2**SELW];
    // unpopulated select codes read as zero
    for (genvar k = 0; k < 2**SELW; k++) begin : g_ch
        if (k < NCH) begin : g_used
            assign ch[k] = in_data[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign ch[k] = '0;
        end
    end
    assign nxt  = idx + 1'b1;
    assign q_n  = ~q;
    assign busy = state == SCAN;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            q       <= '0;
            q_chan  <= '0;
            q_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en_n) begin
                state   <= IDLE;
                idx     <= '0;
                q       <= '0;
                q_valid <= 1'b0;
            end else if (mode == 2'b00) begin
                state   <= IDLE;
                idx     <= '0;
                q       <= ch[sel];
                q_chan  <= sel;
                q_valid <= 1'b1;
            end else if (mode == 2'b11) begin
                state   <= IDLE;
                idx     <= '0;
                q_valid <= 1'b0;
            end else if (state == IDLE) begin
                if (start) begin
                    state   <= SCAN;
                    idx     <= '0;
                    q       <= ch[0];
                    q_chan  <= '0;
                    q_valid <= 1'b1;
                end else begin
                    q_valid <= 1'b0;
                end
            end else if (q_ready) begin
                // q_valid is always set in SCAN, so q_ready alone marks a transfer
                if (idx != LAST) begin
                    idx    <= nxt;
                    q      <= ch[nxt];
                    q_chan <= nxt;
                end else if (mode == 2'b01) begin
                    state   <= IDLE;
                    idx     <= '0;
                    q_valid <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    idx    <= '0;
                    q      <= ch[0];
                    q_chan <= '0;
                end
            end
        end
endmodule

// File: tb/tb_part_mux_scanner.sv
// tb_part_mux_scanner: directed bench for part_mux_scanner with a behavioural reference model
module tb_part_mux_scanner;
    logic        clk = 0, reset_n = 0, en_n = 1, start = 0, q_ready = 1;
    logic [1:0]  mode = 0;
    logic [2:0]  sel = 0;
    logic [7:0]  in8 = 8'b1010_0110;
    logic [19:0] in5 = {4'd7, 4'd6, 4'd5, 4'd4, 4'd3};
    logic [0:0]  q8, qn8;
    logic [3:0]  q5, qn5;
    logic [2:0]  qc8, qc5;
    logic        v8, b8, dn8, v5, b5, dn5;
    int          errs = 0, checks = 0;
    bit          run = 0;
    int          da[8], db[8];
    typedef struct {int q; int ch; bit v; bit scan; bit done; int pos;} ms_t;
    ms_t m8, m5;

    part_mux_scanner #(.WIDTH(1), .NCH(8), .SELW(3)) u8 (
        .clk(clk), .reset_n(reset_n), .in_data(in8), .sel(sel), .en_n(en_n), .mode(mode),
        .start(start), .q(q8), .q_n(qn8), .q_chan(qc8), .q_valid(v8), .q_ready(q_ready),
        .busy(b8), .done(dn8));
    part_mux_scanner #(.WIDTH(4), .NCH(5), .SELW(3)) u5 (
        .clk(clk), .reset_n(reset_n), .in_data(in5), .sel(sel), .en_n(en_n), .mode(mode),
        .start(start), .q(q5), .q_n(qn5), .q_chan(qc5), .q_valid(v5), .q_ready(q_ready),
        .busy(b5), .done(dn5));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    // One clock of the channel sampler, described by its externally visible rules
    function automatic ms_t step(input ms_t s, input bit en, input int md, input bit st,
                                 input bit rdy, input int sl, input int data[8], input int nch);
        ms_t n = s;
        n.done = 0;
        if (en) begin
            n.q = 0; n.v = 0; n.scan = 0; n.pos = 0;
        end else if (md == 0) begin
            n.q = sl < nch ? data[sl] : 0; n.ch = sl; n.v = 1; n.scan = 0; n.pos = 0;
        end else if (md == 3) begin
            n.v = 0; n.scan = 0; n.pos = 0;
        end else if (!s.scan) begin
            if (st) begin
                n.scan = 1; n.pos = 0; n.q = data[0]; n.ch = 0; n.v = 1;
            end else n.v = 0;
        end else if (rdy) begin
            if (s.pos < nch - 1) begin
                n.pos = s.pos + 1; n.q = data[n.pos]; n.ch = n.pos;
            end else if (md == 1) begin
                n.v = 0; n.done = 1; n.scan = 0; n.pos = 0;
            end else begin
                n.pos = 0; n.q = data[0]; n.ch = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            m8 = '{default: 0};
            m5 = '{default: 0};
        end else begin
            for (int k = 0; k < 8; k++) begin
                da[k] = int'(in8[k]);
                db[k] = 0;
                if (k < 5) db[k] = int'(in5[k*4 +: 4]);
            end
            m8 = step(m8, en_n, int'(mode), start, q_ready, int'(sel), da, 8);
            m5 = step(m5, en_n, int'(mode), start, q_ready, int'(sel), db, 5);
        end

    always @(negedge clk)
        if (run) begin
            chk("m8_q", int'(q8), m8.q);
            chk("m8_qn", int'(qn8), m8.q ^ 1);
            chk("m8_chan", int'(qc8), m8.ch);
            chk("m8_valid", int'(v8), int'(m8.v));
            chk("m8_busy", int'(b8), int'(m8.scan));
            chk("m8_done", int'(dn8), int'(m8.done));
            chk("m5_q", int'(q5), m5.q);
            chk("m5_qn", int'(qn5), m5.q ^ 15);
            chk("m5_chan", int'(qc5), m5.ch);
            chk("m5_valid", int'(v5), int'(m5.v));
            chk("m5_busy", int'(b5), int'(m5.scan));
            chk("m5_done", int'(dn5), int'(m5.done));
        end

    initial begin
        int dexp[8] = '{0, 1, 1, 0, 0, 1, 0, 1};
        m8 = '{default: 0};
        m5 = '{default: 0};
        #1;
        chk("rst_q8", int'(q8), 0);
        chk("rst_qn8", int'(qn8), 1);
        chk("rst_q5", int'(q5), 0);
        chk("rst_qn5", int'(qn5), 15);
        chk("rst_valid", int'(v5), 0);
        chk("rst_busy", int'(b5), 0);
        run = 1;
        nx(); nx();
        reset_n = 1;
        en_n = 0; mode = 2'b00;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            nx();
            chk("dir_q", int'(q8), dexp[s]);
            chk("dir_valid", int'(v8), 1);
        end
        en_n = 1; sel = 3'd7;
        nx();
        chk("dis_q", int'(q8), 0);
        chk("dis_valid", int'(v8), 0);
        en_n = 0; mode = 2'b01; start = 1;
        nx();
        start = 0;
        for (int k = 0; k < 5; k++) begin
            chk("once_chan", int'(qc5), k);
            chk("once_q", int'(q5), k + 3);
            nx();
        end
        chk("once_done", int'(dn5), 1);
        chk("once_valid_end", int'(v5), 0);
        nx();
        chk("once_done_pulse", int'(dn5), 0);
        start = 1;
        nx();
        start = 0;
        nx(); nx();
        chk("bp_chan_pre", int'(qc5), 2);
        q_ready = 0;
        for (int i = 0; i < 3; i++) begin
            nx();
            if (i == 0) in5[11:8] = 4'hA;
            chk("bp_chan", int'(qc5), 2);
            chk("bp_q", int'(q5), 5);
        end
        q_ready = 1;
        nx();
        chk("bp_resume_chan", int'(qc5), 3);
        chk("bp_resume_q", int'(q5), 6);
        nx(); nx();
        chk("bp_done", int'(dn5), 1);
        in5[11:8] = 4'd5;
        mode = 2'b10; start = 1;
        nx();
        start = 0;
        for (int i = 0; i < 14; i++) begin
            chk("cont_chan", int'(qc5), i % 5);
            chk("cont_done", int'(dn5), 0);
            if (i < 13) nx();
        end
        mode = 2'b11;
        nx();
        chk("hold_q", int'(q5), 6);
        chk("hold_chan", int'(qc5), 3);
        chk("hold_valid", int'(v5), 0);
        chk("hold_done", int'(dn5), 0);
        mode = 2'b01; start = 1;
        nx();
        start = 0;
        nx(); nx();
        start = 1;
        nx();
        start = 0;
        chk("ign_start_chan", int'(qc5), 3);
        nx();
        chk("ign_start_chan4", int'(qc5), 4);
        nx();
        chk("ign_start_done", int'(dn5), 1);
        en_n = 1; start = 1;
        nx();
        start = 0;
        chk("en_start_busy", int'(b5), 0);
        chk("en_start_valid", int'(v5), 0);
        en_n = 0;
        nx();
        chk("en_start_idle", int'(b5), 0);
        start = 1;
        nx();
        start = 0;
        nx();
        #2 reset_n = 0;
        #1;
        chk("arst_q5", int'(q5), 0);
        chk("arst_qn5", int'(qn5), 15);
        chk("arst_valid", int'(v5), 0);
        chk("arst_busy", int'(b5), 0);
        chk("arst_q8", int'(q8), 0);
        chk("arst_qn8", int'(qn8), 1);
        nx();
        chk("arst_done", int'(dn5), 0);
        reset_n = 1;
        nx(); nx();
        chk("post_rst_done", int'(dn5), 0);
        chk("post_rst_busy", int'(b5), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
